// File: rtl/machine_ctl.sv
// ---------------------------------------------------------------------------
// machine_ctl: instruction-cycle sequencer for the 8-bit RISC CPU.
//
// Locks onto the clock generator's `fetch` phase and then steps through
// eight states, S0..S7, for each instruction. It decodes the opcode captured
// from IR[7:5] into the datapath strobes. It also watches `fetch` for phase
// slips and resynchronises when one occurs.
//
// Ports:
//   i_clk          sequencer clock (clk1 domain), posedge
//   i_reset        synchronous reset, active-low
//   i_fetch        fetch phase: period 8 clk, high 4 clk
//   i_opcode[2:0]  IR[7:5]
//   i_zero         accumulator-zero flag
//   o_inc_pc       PC increment strobe
//   o_load_pc      PC load strobe (jump)
//   o_load_acc     ACC load strobe
//   o_load_ir      IR load strobe
//   o_rd           memory read
//   o_wr           memory write
//   o_datactl_ena  drive ACC onto the data bus
//   o_halt         halt indication
//   o_state[2:0]   current step 0..7 (debug)
//   o_running      locked to fetch and sequencing
//   o_sync_err     sticky fetch misalignment flag
// ---------------------------------------------------------------------------
module machine_ctl #(
  parameter bit HALT_STICKY = 1'b1,
  parameter bit CHECK_SYNC  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_fetch,
  input  logic [2:0] i_opcode,
  input  logic       i_zero,
  output logic       o_inc_pc,
  output logic       o_load_pc,
  output logic       o_load_acc,
  output logic       o_load_ir,
  output logic       o_rd,
  output logic       o_wr,
  output logic       o_datactl_ena,
  output logic       o_halt,
  output logic [2:0] o_state,
  output logic       o_running,
  output logic       o_sync_err
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t     r_state;
  logic       r_running;
  logic       r_halted;
  logic       r_sync_err;
  logic       r_fetch_d;
  logic [2:0] r_op_q;
  logic       r_zero_q;

  state_t     w_state_nxt;
  logic       w_running_nxt;
  logic       w_halted_nxt;
  logic       w_sync_err_nxt;
  logic [2:0] w_op_nxt;
  logic       w_zero_nxt;
  logic       w_rise;
  logic       w_alu;

  assign w_rise = i_fetch & ~r_fetch_d;

  // State register; everything returns to idle on a low reset at the edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S0;
      r_running  <= 1'b0;
      r_halted   <= 1'b0;
      r_sync_err <= 1'b0;
      r_fetch_d  <= 1'b0;
      r_op_q     <= OP_HLT;
      r_zero_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= w_running_nxt;
      r_halted   <= w_halted_nxt;
      r_sync_err <= w_sync_err_nxt;
      r_fetch_d  <= i_fetch;
      r_op_q     <= w_op_nxt;
      r_zero_q   <= w_zero_nxt;
    end
  end

  // Next-state logic. A fetch rise is expected exactly on the S7->S0 edge.
  // A rise anywhere else forces S0. A missing rise at the wrap is flagged,
  // but the wrap still happens. While halted, everything is frozen,
  // including the sync check.
  always_comb begin
    w_state_nxt    = r_state;
    w_running_nxt  = r_running;
    w_halted_nxt   = r_halted;
    w_sync_err_nxt = r_sync_err;
    w_op_nxt       = r_op_q;
    w_zero_nxt     = r_zero_q;
    if (r_halted) begin
      w_state_nxt = r_state;
    end else if (!r_running) begin
      if (w_rise) begin
        w_state_nxt   = S0;
        w_running_nxt = 1'b1;
      end
    end else if (CHECK_SYNC && w_rise && (r_state != S7)) begin
      w_state_nxt    = S0;
      w_sync_err_nxt = 1'b1;
    end else begin
      w_state_nxt = state_t'(3'(r_state + 3'd1));
      if (CHECK_SYNC && (r_state == S7) && !w_rise) begin
        w_sync_err_nxt = 1'b1;
      end
      if (r_state == S2) begin
        w_op_nxt = i_opcode;
      end
      if (r_state == S4) begin
        w_zero_nxt = i_zero;
      end
      // The increment already lands on S4, which is where the state parks.
      if (HALT_STICKY && (r_state == S3) && (r_op_q == OP_HLT)) begin
        w_halted_nxt  = 1'b1;
        w_running_nxt = 1'b0;
      end
    end
  end

  assign w_alu = (r_op_q == OP_ADD) || (r_op_q == OP_AND) ||
                 (r_op_q == OP_XOR) || (r_op_q == OP_LDA);

  // Strobe decode from (state, captured opcode, captured zero). All strobes
  // are silent until the sequencer has locked.
  always_comb begin
    o_inc_pc      = 1'b0;
    o_load_pc     = 1'b0;
    o_load_acc    = 1'b0;
    o_load_ir     = 1'b0;
    o_rd          = 1'b0;
    o_wr          = 1'b0;
    o_datactl_ena = 1'b0;
    o_halt        = 1'b0;
    if (r_halted) begin
      o_halt = 1'b1;
    end else if (r_running) begin
      case (r_state)
        S0: begin
          o_rd      = 1'b1;
          o_load_ir = 1'b1;
        end
        S1: begin
          o_rd      = 1'b1;
          o_load_ir = 1'b1;
          o_inc_pc  = 1'b1;
        end
        S2: begin
          o_rd = 1'b0;
        end
        S3: begin
          o_inc_pc = 1'b1;
          o_halt   = (r_op_q == OP_HLT);
        end
        S4: begin
          o_rd          = w_alu;
          o_load_pc     = (r_op_q == OP_JMP);
          o_datactl_ena = (r_op_q == OP_STO);
        end
        S5: begin
          o_rd          = w_alu;
          o_load_acc    = w_alu;
          o_load_pc     = (r_op_q == OP_JMP);
          o_inc_pc      = (r_op_q == OP_JMP) || ((r_op_q == OP_SKZ) && r_zero_q);
          o_wr          = (r_op_q == OP_STO);
          o_datactl_ena = (r_op_q == OP_STO);
        end
        S6: begin
          o_rd          = w_alu;
          o_datactl_ena = (r_op_q == OP_STO);
        end
        S7: begin
          o_inc_pc = (r_op_q == OP_SKZ) && r_zero_q;
        end
        default: begin
          o_rd = 1'b0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_running  = r_running;
  assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_machine_ctl.sv
// ---------------------------------------------------------------------------
// tb_machine_ctl: directed, table-driven bench for machine_ctl.
// Strobes are compared as one byte:
//   {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt}
// ---------------------------------------------------------------------------
module tb_machine_ctl;

  typedef struct {
    logic [2:0] op;
    logic       zero;
    logic [7:0] e3;
    logic [7:0] e4;
    logic [7:0] e5;
    logic [7:0] e6;
    logic [7:0] e7;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       fetch;
  logic [2:0] opcode;
  logic       zero;
  logic       incPc, loadPc, loadAcc, loadIr, rd, wr, datactlEna, halt;
  logic [2:0] state;
  logic       running;
  logic       syncErr;
  logic [7:0] strobes;

  int   errors;
  int   checks;
  int   phase;
  logic expSync;
  vec_t vecs[10];

  assign strobes = {incPc, loadPc, loadAcc, loadIr, rd, wr, datactlEna, halt};

  machine_ctl #(.HALT_STICKY(1'b1), .CHECK_SYNC(1'b1)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_fetch(fetch),
    .i_opcode(opcode),
    .i_zero(zero),
    .o_inc_pc(incPc),
    .o_load_pc(loadPc),
    .o_load_acc(loadAcc),
    .o_load_ir(loadIr),
    .o_rd(rd),
    .o_wr(wr),
    .o_datactl_ena(datactlEna),
    .o_halt(halt),
    .o_state(state),
    .o_running(running),
    .o_sync_err(syncErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string what, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  // Drive fetch from the phase counter, clock one edge, then settle.
  task automatic clockCycle();
    fetch = (phase < 4);
    @(posedge clk);
    #1;
    phase = (phase + 1) % 8;
  endtask

  function automatic logic [7:0] expFor(input vec_t v, input int k);
    case (k)
      0: return 8'h18;
      1: return 8'h98;
      2: return 8'h00;
      3: return v.e3;
      4: return v.e4;
      5: return v.e5;
      6: return v.e6;
      default: return v.e7;
    endcase
  endfunction

  // Runs one full instruction from a sampled S0 and checks every step.
  task automatic applyStimulus(input vec_t v);
    opcode = v.op;
    zero   = v.zero;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("op%b z%0d state@%0d", v.op, v.zero, k), {5'b0, state}, 8'(k));
      checkOutput($sformatf("op%b z%0d strobes@S%0d", v.op, v.zero, k), strobes, expFor(v, k));
      checkOutput($sformatf("op%b syncErr@S%0d", v.op, k), {7'b0, syncErr}, {7'b0, expSync});
      checkOutput($sformatf("op%b running@S%0d", v.op, k), {7'b0, running}, 8'h01);
      checkOutput($sformatf("op%b rd&wr@S%0d", v.op, k), {7'b0, rd & wr}, 8'h00);
      clockCycle();
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    expSync = 1'b0;
    //               op     z     S3     S4     S5     S6     S7
    vecs[0] = '{3'b101, 1'b0, 8'h80, 8'h08, 8'h28, 8'h08, 8'h00}; // LDA
    vecs[1] = '{3'b010, 1'b1, 8'h80, 8'h08, 8'h28, 8'h08, 8'h00}; // ADD
    vecs[2] = '{3'b011, 1'b0, 8'h80, 8'h08, 8'h28, 8'h08, 8'h00}; // AND
    vecs[3] = '{3'b100, 1'b0, 8'h80, 8'h08, 8'h28, 8'h08, 8'h00}; // XOR
    vecs[4] = '{3'b110, 1'b0, 8'h80, 8'h02, 8'h06, 8'h02, 8'h00}; // STO
    vecs[5] = '{3'b111, 1'b0, 8'h80, 8'h40, 8'hC0, 8'h00, 8'h00}; // JMP
    vecs[6] = '{3'b001, 1'b1, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80}; // SKZ taken
    vecs[7] = '{3'b001, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}; // SKZ not taken
    vecs[8] = '{3'b110, 1'b1, 8'h80, 8'h02, 8'h06, 8'h02, 8'h00}; // STO
    vecs[9] = '{3'b101, 1'b1, 8'h80, 8'h08, 8'h28, 8'h08, 8'h00}; // LDA

    // Hold reset with fetch low.
    reset  = 1'b0;
    fetch  = 1'b0;
    opcode = 3'b000;
    zero   = 1'b0;
    phase  = 4;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", {5'b0, state}, 8'h00);
    checkOutput("reset strobes", strobes, 8'h00);
    checkOutput("reset running", {7'b0, running}, 8'h00);
    checkOutput("reset syncErr", {7'b0, syncErr}, 8'h00);

    // Release reset; the sequencer stays idle until fetch rises.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clockCycle();
      checkOutput("prelock running", {7'b0, running}, 8'h00);
      checkOutput("prelock strobes", strobes, 8'h00);
    end
    clockCycle();
    checkOutput("lock running", {7'b0, running}, 8'h01);
    checkOutput("lock state", {5'b0, state}, 8'h00);

    // Ten aligned instructions from the table.
    for (int n = 0; n < 10; n++) begin
      applyStimulus(vecs[n]);
    end

    // Move fetch 2 clk earlier. It rises while the sequencer is in S5.
    opcode = 3'b101;
    phase  = 3;
    for (int i = 0; i < 5; i++) begin
      clockCycle();
      checkOutput("slip pre state", {5'b0, state}, 8'(i + 1));
      checkOutput("slip pre syncErr", {7'b0, syncErr}, 8'h00);
    end
    clockCycle();
    checkOutput("slip resync state", {5'b0, state}, 8'h00);
    checkOutput("slip syncErr", {7'b0, syncErr}, 8'h01);
    checkOutput("slip running", {7'b0, running}, 8'h01);
    expSync = 1'b1;
    applyStimulus(vecs[0]);

    // Sticky HLT: the state parks at 4 with only halt asserted.
    opcode = 3'b000;
    zero   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("hlt state", {5'b0, state}, 8'(k));
      checkOutput("hlt strobes", strobes, (k == 3) ? 8'h81 : ((k == 2) ? 8'h00 : ((k == 1) ? 8'h98 : 8'h18)));
      clockCycle();
    end
    for (int i = 0; i < 50; i++) begin
      checkOutput("halted state", {5'b0, state}, 8'h04);
      checkOutput("halted strobes", strobes, 8'h01);
      checkOutput("halted running", {7'b0, running}, 8'h00);
      checkOutput("halted syncErr", {7'b0, syncErr}, 8'h01);
      clockCycle();
    end

    // A single reset edge clears the halt and the sync error.
    reset = 1'b0;
    clockCycle();
    checkOutput("unhalt state", {5'b0, state}, 8'h00);
    checkOutput("unhalt strobes", strobes, 8'h00);
    checkOutput("unhalt running", {7'b0, running}, 8'h00);
    checkOutput("unhalt syncErr", {7'b0, syncErr}, 8'h00);
    reset   = 1'b1;
    expSync = 1'b0;
    phase   = 4;
    for (int i = 0; i < 4; i++) begin
      clockCycle();
    end
    clockCycle();
    checkOutput("relock running", {7'b0, running}, 8'h01);
    applyStimulus(vecs[5]);

    // Reset in the middle of an instruction drops the strobes on that edge.
    opcode = 3'b101;
    for (int i = 0; i < 5; i++) begin
      clockCycle();
    end
    checkOutput("midrst pre strobes", strobes, 8'h28);
    reset = 1'b0;
    clockCycle();
    checkOutput("midrst strobes", strobes, 8'h00);
    checkOutput("midrst state", {5'b0, state}, 8'h00);
    checkOutput("midrst running", {7'b0, running}, 8'h00);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
